// File: rtl/hcpu_pkg.sv
// hcpu shared definitions: opcodes, SYS sub-codes and FSM states.
package hcpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_BRC = 3'b101;
  localparam logic [2:0] OP_BRB = 3'b110;
  localparam logic [2:0] OP_SYS = 3'b111;

  localparam int SYS_JMP = 0;
  localparam int SYS_TGL = 1;
  localparam int SYS_HLT = 2;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

endpackage

// File: rtl/hcpu_alu.sv
// hcpu combinational ALU: result, flags and register write enable.
module hcpu_alu
  import hcpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              borrow_out,
  output logic              write_en
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    result     = '0;
    write_en   = 1'b0;
    carry_out  = sum[DATA_W];
    borrow_out = (a < b);
    unique case (op)
      OP_ADD: begin
        result   = sum[DATA_W-1:0];
        write_en = 1'b1;
      end
      OP_SUB: begin
        result   = a - b;
        write_en = 1'b1;
      end
      OP_AND: begin
        result   = a & b;
        write_en = 1'b1;
      end
      OP_XOR: begin
        result   = a ^ b;
        write_en = 1'b1;
      end
      OP_MOV: begin
        result   = b;
        write_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hcpu_core.sv
// hcpu core: fetch/exec/halt FSM, register file, pc and flags.
module hcpu_core
  import hcpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2,
  parameter int PC_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3+2*RADDR_W-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [PC_W-1:0]        pc,
  output logic [DATA_W-1:0]      out_data,
  output logic                   carry,
  output logic                   borrow,
  output logic                   halted
);

  localparam int NREGS = 2**RADDR_W;
  localparam int IW    = 3 + 2*RADDR_W;

  state_e              state_q, state_d;
  logic [IW-1:0]       instr_q, instr_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;
  logic                out_sel_q, out_sel_d;
  logic [DATA_W-1:0]   regs_q [NREGS];

  logic [2:0]          op;
  logic [RADDR_W-1:0]  rd, rs;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_b, alu_we;
  logic                rf_we;
  logic [PC_W-1:0]     pc_inc, br_tgt;

  assign op = instr_q[IW-1 -: 3];
  assign rd = instr_q[2*RADDR_W-1 -: RADDR_W];
  assign rs = instr_q[RADDR_W-1:0];

  assign pc_inc = pc_q + PC_W'(1);
  assign br_tgt = pc_q + PC_W'(regs_q[NREGS-1]);

  hcpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op         (op),
    .a          (regs_q[rd]),
    .b          (regs_q[rs]),
    .result     (alu_res),
    .carry_out  (alu_c),
    .borrow_out (alu_b),
    .write_en   (alu_we)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    carry_d   = carry_q;
    borrow_d  = borrow_q;
    out_sel_d = out_sel_q;
    rf_we     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        rf_we   = alu_we;
        if (op == OP_ADD) carry_d = alu_c;
        if (op == OP_SUB) borrow_d = alu_b;
        if (op == OP_BRC && carry_q) pc_d = br_tgt;
        if (op == OP_BRB && borrow_q) pc_d = br_tgt;
        if (op == OP_SYS) begin
          if (rs == RADDR_W'(SYS_JMP)) begin
            pc_d = br_tgt;
          end else if (rs == RADDR_W'(SYS_TGL)) begin
            out_sel_d = ~out_sel_q;
          end else if (rs == RADDR_W'(SYS_HLT)) begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // R[i]=i after reset gives the program known constants to start from
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instr_q   <= '0;
      pc_q      <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      out_sel_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      carry_q   <= carry_d;
      borrow_q  <= borrow_d;
      out_sel_q <= out_sel_d;
      if (rf_we) regs_q[rd] <= alu_res;
    end
  end

  assign instr_ready = (state_q == S_FETCH);
  assign halted      = (state_q == S_HALT);
  assign pc          = pc_q;
  assign carry       = carry_q;
  assign borrow      = borrow_q;
  assign out_data    = out_sel_q ? regs_q[NREGS-1] : DATA_W'(pc_q);

endmodule
